// File: rtl/qpu_exu_tiq_pkg.sv
// Shared definitions for the EXU time-instruction queue.
package qpu_exu_tiq_pkg;

    localparam int unsigned QPU_TIME_WIDTH    = 32;
    localparam int unsigned QPU_TIQ_DEPTH     = 8;
    localparam int unsigned QPU_TIQ_CNT_WIDTH = $clog2(QPU_TIQ_DEPTH) + 1;

    // Timeline state mirrors run_i directly; there is no separate state register.
    typedef enum logic {
        TIQ_IDLE = 1'b0,
        TIQ_RUN  = 1'b1
    } tiq_state_e;

endpackage : qpu_exu_tiq_pkg

// File: rtl/qpu_tiq_fifo.sv
// Generic synchronous circular FIFO with flush; head data is combinational.
module qpu_tiq_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           head_data_c,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_c;
    logic             pop_c;

    // Pointer and occupancy next-state; flush wins, a push while full is dropped.
    always_comb begin
        push_c  = push_i & ~full_q;
        pop_c   = pop_i & ~empty_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_c) wptr_d = wptr_q + PTR_W'(1);
            if (pop_c)  rptr_d = rptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Storage write; a flushed push never lands.
    always_comb begin
        mem_d = mem_q;
        if (push_c && !flush_i) mem_d[wptr_q] = data_i;
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage array carries no reset; contents are qualified by count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data_c = mem_q[rptr_q];
    assign count_o     = count_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;

endmodule : qpu_tiq_fifo

// File: rtl/qpu_exu_tiq.sv
// Time-instruction queue: buffers time points and fires each when the timeline reaches it.
module qpu_exu_tiq
    import qpu_exu_tiq_pkg::*;
#(
    parameter int unsigned DEPTH      = QPU_TIQ_DEPTH,
    parameter int unsigned TIME_WIDTH = QPU_TIME_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tiq_wbck_i_ena,
    input  logic [TIME_WIDTH-1:0]   tiq_wbck_i_data,
    output logic                    tiq_wbck_i_ready,
    input  logic                    run_i,
    input  logic                    flush_i,
    output logic                    tiq_trig_o,
    output logic [TIME_WIDTH-1:0]   tiq_trig_time_o,
    output logic [TIME_WIDTH-1:0]   tiq_timer_o,
    output logic [$clog2(DEPTH):0]  tiq_count_o,
    output logic                    tiq_empty_o,
    output logic                    tiq_full_o,
    output logic                    tiq_late_o,
    output logic                    tiq_ovf_o
);

    logic [TIME_WIDTH-1:0] timer_q, timer_d;
    logic [TIME_WIDTH-1:0] trig_time_q, trig_time_d;
    logic                  trig_q, trig_d;
    logic                  late_q, late_d;
    logic                  ovf_q, ovf_d;
    logic [TIME_WIDTH-1:0] head_data_c;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push_c;
    logic                  fire_c;
    tiq_state_e            state_c;

    assign state_c = tiq_state_e'(run_i);
    assign push_c  = tiq_wbck_i_ena & ~fifo_full;
    assign fire_c  = (state_c == TIQ_RUN) & ~fifo_empty & (head_data_c <= timer_q);

    qpu_tiq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TIME_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_c),
        .pop_i       (fire_c),
        .flush_i     (flush_i),
        .data_i      (tiq_wbck_i_data),
        .head_data_c (head_data_c),
        .count_o     (tiq_count_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Timeline, trigger and sticky-flag next state; flush overrides everything.
    always_comb begin
        timer_d     = timer_q;
        trig_d      = 1'b0;
        trig_time_d = trig_time_q;
        late_d      = late_q;
        ovf_d       = ovf_q;
        if (flush_i) begin
            timer_d = '0;
            late_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            if (fire_c) begin
                trig_d      = 1'b1;
                trig_time_d = head_data_c;
                if (head_data_c < timer_q) late_d = 1'b1;
            end
            if (state_c == TIQ_RUN) begin
                if (&timer_q) ovf_d   = 1'b1;
                else          timer_d = timer_q + TIME_WIDTH'(1);
            end
        end
    end

    // Timeline and trigger registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q     <= '0;
            trig_q      <= 1'b0;
            trig_time_q <= '0;
            late_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            trig_q      <= trig_d;
            trig_time_q <= trig_time_d;
            late_q      <= late_d;
            ovf_q       <= ovf_d;
        end
    end

    assign tiq_wbck_i_ready = ~fifo_full;
    assign tiq_full_o       = fifo_full;
    assign tiq_empty_o      = fifo_empty;
    assign tiq_trig_o       = trig_q;
    assign tiq_trig_time_o  = trig_time_q;
    assign tiq_timer_o      = timer_q;
    assign tiq_late_o       = late_q;
    assign tiq_ovf_o        = ovf_q;

endmodule : qpu_exu_tiq

// File: tb/tb_qpu_exu_tiq.sv
// Self-checking bench for qpu_exu_tiq against a queue-based reference model.
module tb_qpu_exu_tiq;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TW    = 10;
    localparam int unsigned TMAX  = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic [TW-1:0] data;
    logic          run;
    logic          flush;
    logic          tiq_wbck_i_ready;
    logic          tiq_trig_o;
    logic [TW-1:0] tiq_trig_time_o;
    logic [TW-1:0] tiq_timer_o;
    logic [3:0]    tiq_count_o;
    logic          tiq_empty_o;
    logic          tiq_full_o;
    logic          tiq_late_o;
    logic          tiq_ovf_o;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    int unsigned m_q[$];
    int unsigned m_timer;
    int unsigned m_trig_time;
    bit          m_trig;
    bit          m_late;
    bit          m_ovf;

    qpu_exu_tiq #(
        .DEPTH      (DEPTH),
        .TIME_WIDTH (TW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tiq_wbck_i_ena   (ena),
        .tiq_wbck_i_data  (data),
        .tiq_wbck_i_ready (tiq_wbck_i_ready),
        .run_i            (run),
        .flush_i          (flush),
        .tiq_trig_o       (tiq_trig_o),
        .tiq_trig_time_o  (tiq_trig_time_o),
        .tiq_timer_o      (tiq_timer_o),
        .tiq_count_o      (tiq_count_o),
        .tiq_empty_o      (tiq_empty_o),
        .tiq_full_o       (tiq_full_o),
        .tiq_late_o       (tiq_late_o),
        .tiq_ovf_o        (tiq_ovf_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model by the queue rules, then settle after the edge.
    task automatic step(input bit e, input int unsigned d, input bit r, input bit f);
        bit          fire;
        bit          accept;
        int unsigned head;
        ena   = e;
        data  = TW'(d);
        run   = r;
        flush = f;
        fire   = r && (m_q.size() > 0) && (m_q[0] <= m_timer);
        accept = e && (m_q.size() < DEPTH);
        if (f) begin
            m_q.delete();
            m_timer = 0;
            m_late  = 0;
            m_ovf   = 0;
            m_trig  = 0;
        end else begin
            m_trig = fire;
            if (fire) begin
                head        = m_q.pop_front();
                m_trig_time = head;
                if (head < m_timer) m_late = 1;
            end
            if (accept) m_q.push_back(d);
            if (r) begin
                if (m_timer == TMAX) m_ovf = 1;
                else                 m_timer = m_timer + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b0; data = '0; run = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_q.delete(); m_timer = 0; m_late = 0; m_ovf = 0; m_trig = 0; m_trig_time = 0;
        n_cmp++;
        if (tiq_wbck_i_ready !== 1'b1 || tiq_empty_o !== 1'b1 || tiq_full_o !== 1'b0 ||
            tiq_count_o !== 4'd0 || tiq_trig_o !== 1'b0 || tiq_trig_time_o !== '0 ||
            tiq_timer_o !== '0 || tiq_late_o !== 1'b0 || tiq_ovf_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: got rdy=%b emp=%b full=%b cnt=%0d trig=%b tt=%0d tmr=%0d late=%b ovf=%b, need 1 1 0 0 0 0 0 0 0",
                     tiq_wbck_i_ready, tiq_empty_o, tiq_full_o, tiq_count_o, tiq_trig_o,
                     tiq_trig_time_o, tiq_timer_o, tiq_late_o, tiq_ovf_o);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            n_cmp++;
            if (tiq_timer_o !== '0 || tiq_wbck_i_ready !== 1'b1 || tiq_empty_o !== 1'b1 || tiq_trig_o !== 1'b0) begin
                n_err++;
                $display("FAIL idle_hold: cycle %0d tmr=%0d rdy=%b emp=%b trig=%b, need 0 1 1 0",
                         i, tiq_timer_o, tiq_wbck_i_ready, tiq_empty_o, tiq_trig_o);
            end
        end
    endtask

    task automatic test_order();
        int unsigned got_t[$];
        int unsigned got_l[$];
        int unsigned got_tm[$];
        int unsigned exp_t[3]  = '{3, 5, 5};
        int unsigned exp_l[3]  = '{0, 0, 1};
        int unsigned exp_tm[3] = '{4, 6, 7};
        step(0, 0, 0, 1);
        step(1, 3, 0, 0);
        step(1, 5, 0, 0);
        step(1, 5, 0, 0);
        n_cmp++;
        if (tiq_count_o !== 4'(m_q.size()) || tiq_timer_o !== '0) begin
            n_err++;
            $display("FAIL order_preload: cnt=%0d tmr=%0d, need %0d 0", tiq_count_o, tiq_timer_o, m_q.size());
        end
        for (int i = 0; i < 30 && got_t.size() < 3; i++) begin
            step(0, 0, 1, 0);
            n_cmp++;
            if (tiq_trig_o !== m_trig) begin
                n_err++;
                $display("FAIL order_trig: cycle %0d trig=%b need %b", i, tiq_trig_o, m_trig);
            end
            if (tiq_trig_o === 1'b1) begin
                got_t.push_back(int'(tiq_trig_time_o));
                got_l.push_back(int'(tiq_late_o));
                got_tm.push_back(int'(tiq_timer_o));
            end
        end
        n_cmp++;
        if (got_t.size() != 3) begin
            n_err++;
            $display("FAIL order_count: got %0d pulses, need 3", got_t.size());
        end
        for (int i = 0; i < 3 && i < got_t.size(); i++) begin
            n_cmp++;
            if (got_t[i] != exp_t[i] || got_l[i] != exp_l[i] || got_tm[i] != exp_tm[i]) begin
                n_err++;
                $display("FAIL order_pulse%0d: time=%0d late=%0d tmr=%0d, need %0d %0d %0d",
                         i, got_t[i], got_l[i], got_tm[i], exp_t[i], exp_l[i], exp_tm[i]);
            end
        end
    endtask

    task automatic test_full();
        int unsigned got_t[$];
        bit          pushed;
        bit          e;
        step(0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 100, 0, 0);
        n_cmp++;
        if (tiq_full_o !== 1'b1 || tiq_wbck_i_ready !== 1'b0 || tiq_count_o !== 4'd8) begin
            n_err++;
            $display("FAIL full_flags: full=%b rdy=%b cnt=%0d, need 1 0 8", tiq_full_o, tiq_wbck_i_ready, tiq_count_o);
        end
        step(1, 55, 0, 0);
        n_cmp++;
        if (tiq_count_o !== 4'd8 || tiq_full_o !== 1'b1) begin
            n_err++;
            $display("FAIL full_ignore: cnt=%0d full=%b, need 8 1", tiq_count_o, tiq_full_o);
        end
        pushed = 0;
        for (int i = 0; i < 400 && got_t.size() < DEPTH + 1; i++) begin
            e = !pushed && (tiq_wbck_i_ready === 1'b1);
            if (e) begin
                n_cmp++;
                if (tiq_count_o !== 4'd7) begin
                    n_err++;
                    $display("FAIL full_release: cnt=%0d when ready rose, need 7", tiq_count_o);
                end
                pushed = 1;
            end
            step(e, 200, 1, 0);
            n_cmp++;
            if (tiq_count_o !== 4'(m_q.size()) || tiq_trig_o !== m_trig) begin
                n_err++;
                $display("FAIL full_drain: cycle %0d cnt=%0d trig=%b, need %0d %b",
                         i, tiq_count_o, tiq_trig_o, m_q.size(), m_trig);
            end
            if (tiq_trig_o === 1'b1) got_t.push_back(int'(tiq_trig_time_o));
        end
        n_cmp++;
        if (got_t.size() != DEPTH + 1) begin
            n_err++;
            $display("FAIL full_pulses: got %0d, need %0d", got_t.size(), DEPTH + 1);
        end
        for (int i = 0; i < got_t.size(); i++) begin
            n_cmp++;
            if (got_t[i] != ((i < DEPTH) ? 100 : 200)) begin
                n_err++;
                $display("FAIL full_order%0d: time=%0d need %0d", i, got_t[i], (i < DEPTH) ? 100 : 200);
            end
        end
    endtask

    task automatic test_saturate();
        step(0, 0, 0, 1);
        for (int i = 0; i < TMAX; i++) step(0, 0, 1, 0);
        n_cmp++;
        if (tiq_timer_o !== TW'(TMAX) || tiq_ovf_o !== 1'b0) begin
            n_err++;
            $display("FAIL sat_reach: tmr=%0d ovf=%b, need %0d 0", tiq_timer_o, tiq_ovf_o, TMAX);
        end
        step(1, 5, 1, 0);
        n_cmp++;
        if (tiq_timer_o !== TW'(TMAX) || tiq_ovf_o !== 1'b1) begin
            n_err++;
            $display("FAIL sat_ovf: tmr=%0d ovf=%b, need %0d 1", tiq_timer_o, tiq_ovf_o, TMAX);
        end
        step(0, 0, 1, 0);
        n_cmp++;
        if (tiq_trig_o !== 1'b1 || tiq_trig_time_o !== TW'(5) || tiq_late_o !== 1'b1) begin
            n_err++;
            $display("FAIL sat_late: trig=%b tt=%0d late=%b, need 1 5 1", tiq_trig_o, tiq_trig_time_o, tiq_late_o);
        end
        step(1, 9, 0, 0);
        step(0, 0, 0, 1);
        n_cmp++;
        if (tiq_timer_o !== '0 || tiq_ovf_o !== 1'b0 || tiq_late_o !== 1'b0 ||
            tiq_count_o !== 4'd0 || tiq_empty_o !== 1'b1) begin
            n_err++;
            $display("FAIL sat_flush: tmr=%0d ovf=%b late=%b cnt=%0d emp=%b, need 0 0 0 0 1",
                     tiq_timer_o, tiq_ovf_o, tiq_late_o, tiq_count_o, tiq_empty_o);
        end
    endtask

    task automatic test_flush_same();
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        step(1, 7, 1, 1);
        n_cmp++;
        if (tiq_empty_o !== 1'b1 || tiq_count_o !== 4'd0 || tiq_trig_o !== 1'b0 || tiq_timer_o !== '0) begin
            n_err++;
            $display("FAIL flush_same: emp=%b cnt=%0d trig=%b tmr=%0d, need 1 0 0 0",
                     tiq_empty_o, tiq_count_o, tiq_trig_o, tiq_timer_o);
        end
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 1, 0);
            n_cmp++;
            if (tiq_trig_o !== 1'b0) begin
                n_err++;
                $display("FAIL flush_absent: cycle %0d trig=%b tt=%0d, need no pulse", i, tiq_trig_o, tiq_trig_time_o);
            end
        end
    endtask

    task automatic test_random();
        bit          e;
        bit          r;
        bit          f;
        int unsigned d;
        step(0, 0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            r = ($urandom % 4) != 0;
            f = ($urandom % 64) == 0;
            e = (($urandom % 2) == 1) && (m_q.size() < DEPTH);
            d = m_timer + $urandom_range(0, 12);
            if (d > TMAX) d = TMAX;
            step(e, d, r, f);
            n_cmp++;
            if (tiq_timer_o !== TW'(m_timer) || tiq_trig_o !== m_trig ||
                (m_trig && tiq_trig_time_o !== TW'(m_trig_time)) ||
                tiq_count_o !== 4'(m_q.size()) || tiq_empty_o !== (m_q.size() == 0) ||
                tiq_full_o !== (m_q.size() == DEPTH) || tiq_wbck_i_ready !== (m_q.size() != DEPTH) ||
                tiq_late_o !== m_late || tiq_ovf_o !== m_ovf) begin
                n_err++;
                $display("FAIL random: cycle %0d tmr=%0d trig=%b tt=%0d cnt=%0d late=%b ovf=%b, need %0d %b %0d %0d %b %b",
                         i, tiq_timer_o, tiq_trig_o, tiq_trig_time_o, tiq_count_o, tiq_late_o, tiq_ovf_o,
                         m_timer, m_trig, m_trig_time, m_q.size(), m_late, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_full();
        test_saturate();
        test_flush_same();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_qpu_exu_tiq
